reg_scoreboard: RTL and testbench

- Tracks outstanding register writes between decode (ID) and write-back (WB) in the 5-stage MIPS pipeline.
- Generates the decode stall for RAW hazards on the 32x32 register file, and for WAW saturation.
- Sits beside the register file:
  - Issue side is driven by the ID stage.
  - Retire side is driven by the same write_enable/dest pair that feeds the register file write port.

---
 rtl/reg_scoreboard.sv | 116 +++++++++++
 tb/tb_reg_scoreboard.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: counts outstanding writes per architectural
// register between ID and WB, and raises the decode stall on RAW hazards and
// on saturation of a register's pending-write counter.

// One pending-write counter for a single architectural register.
module reg_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  // Issue and retire in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (inc && !dec)  cnt <= cnt + 1'b1;
    else if (dec && !inc)  cnt <= cnt - 1'b1;
  end

endmodule

module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_src1,
  input  logic                id_src1_used,
  input  logic [ADDR_W-1:0]   id_src2,
  input  logic                id_src2_used,
  input  logic [ADDR_W-1:0]   id_dest,
  input  logic                id_writes,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [TOT_W-1:0]    inflight_cnt,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_s1, cnt_s2, cnt_dst, cnt_wb;
  logic             haz1, haz2, waw;
  logic             issue, inc, dec, wb_nz;
  logic [TOT_W-1:0] tot;
  logic             err;

  assign cnt_s1  = cnt[id_src1];
  assign cnt_s2  = cnt[id_src2];
  assign cnt_dst = cnt[id_dest];
  assign cnt_wb  = cnt[wb_dest];
  assign wb_nz   = wb_valid && (wb_dest != '0);

  // Hazard decode. A source whose last outstanding write retires this cycle
  // is not a hazard: the register file writes on the falling edge and ID
  // reads it combinationally. A full counter only clears if WB frees a slot.
  always_comb begin
    haz1  = 1'b0;
    haz2  = 1'b0;
    waw   = 1'b0;
    stall = 1'b0;
    if (id_src1_used && id_src1 != '0 && cnt_s1 != '0)
      haz1 = !(wb_valid && wb_dest == id_src1 && cnt_s1 == ONE);
    if (id_src2_used && id_src2 != '0 && cnt_s2 != '0)
      haz2 = !(wb_valid && wb_dest == id_src2 && cnt_s2 == ONE);
    if (id_writes && id_dest != '0 && cnt_dst == MAX_CNT)
      waw = !(wb_valid && wb_dest == id_dest);
    stall = id_valid && (haz1 || haz2 || waw);
  end

  assign issue = id_valid && !stall;
  assign inc   = issue && id_writes && (id_dest != '0);
  assign dec   = wb_nz && (cnt_wb != '0);

  // Register 0 is hard-wired zero and never tracked.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign cnt[g] = '0;
    end else begin : g_cnt
      reg_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc && id_dest == ADDR_W'(g)),
        .dec (dec && wb_dest == ADDR_W'(g)),
        .cnt (cnt[g])
      );
    end
    assign pending_mask[g] = |cnt[g];
  end

  // Total in-flight writes; bounded by pipeline depth so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tot <= '0;
    else     tot <= tot + TOT_W'(inc) - TOT_W'(dec);
  end

  // Sticky error on a write-back with nothing pending for that register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err <= 1'b0;
    else if (wb_nz && cnt_wb == '0)   err <= 1'b1;
  end

  assign inflight_cnt  = tot;
  assign underflow_err = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a table of per-cycle vectors with
// hand-computed expectations, plus a mid-cycle reset sequence.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_src1_used, id_src2_used, id_writes, wb_valid;
  logic [4:0]  id_src1, id_src2, id_dest, wb_dest;
  logic        stall, underflow_err;
  logic [31:0] pending_mask;
  logic [3:0]  inflight_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .TOT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_writes(id_writes),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .stall(stall), .pending_mask(pending_mask),
    .inflight_cnt(inflight_cnt), .underflow_err(underflow_err)
  );

  typedef struct {
    logic        vld;
    logic [4:0]  s1;
    logic        s1u;
    logic [4:0]  s2;
    logic        s2u;
    logic [4:0]  dst;
    logic        wr;
    logic        wbv;
    logic [4:0]  wbd;
    logic        stall;   // expected before the edge
    logic [31:0] mask;    // expected after the edge
    logic [3:0]  infl;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vld, logic [4:0] s1, logic s1u,
                              logic [4:0] s2, logic s2u, logic [4:0] dst,
                              logic wr, logic wbv, logic [4:0] wbd,
                              logic st, logic [31:0] mask, logic [3:0] infl,
                              logic err);
    vec_t v;
    v.vld = vld; v.s1 = s1; v.s1u = s1u; v.s2 = s2; v.s2u = s2u;
    v.dst = dst; v.wr = wr; v.wbv = wbv; v.wbd = wbd;
    v.stall = st; v.mask = mask; v.infl = infl; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_src1 = v.s1; id_src1_used = v.s1u;
    id_src2 = v.s2; id_src2_used = v.s2u; id_dest = v.dst;
    id_writes = v.wr; wb_valid = v.wbv; wb_dest = v.wbd;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'd0, 0);
    //        vld s1 u  s2 u  dst wr wbv wbd  stall mask          infl  err
    // RAW on r8, released by write-through in the WB cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0,  0, 32'h0000_0100, 4'd1, 0));
    vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0100, 4'd1, 0));
    vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0100, 4'd1, 0));
    vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 1, 8,  0, 32'h0000_0000, 4'd0, 0));
    // Register 0: never tracked, never stalls, WB to r0 raises no error
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 32'h0000_0000, 4'd0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 0,  0, 32'h0000_0000, 4'd0, 0));
    // Same-cycle issue and WB on r3, with an r3 consumer
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 32'h0000_0008, 4'd1, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 3, 1, 1, 3,  0, 32'h0000_0008, 4'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 32'h0000_0000, 4'd0, 0));
    // WAW saturation on r9
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 32'h0000_0200, 4'd1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 32'h0000_0200, 4'd2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 32'h0000_0200, 4'd3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  1, 32'h0000_0200, 4'd3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 9,  0, 32'h0000_0200, 4'd3, 0));
    // cnt[9]=3: WB does not unblock a reader until it is the last write
    vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 1, 9,  1, 32'h0000_0200, 4'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 32'h0000_0200, 4'd1, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 1, 9,  0, 32'h0000_0000, 4'd0, 0));
    // Underflow on r12, sticky
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 32'h0000_0000, 4'd0, 1));
    vecs.push_back(mk(1, 0, 0, 12, 1, 5, 1, 0, 0, 0, 32'h0000_0020, 4'd1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 32'h0000_0020, 4'd2, 1));
    // Pending r5 read with id_valid low / with src unused: no stall
    vecs.push_back(mk(0, 5, 1, 0, 0, 0, 0, 0, 0,  0, 32'h0000_0020, 4'd2, 1));
    vecs.push_back(mk(1, 5, 0, 5, 0, 0, 0, 0, 0,  0, 32'h0000_0020, 4'd2, 1));

    // Reset state
    rst = 1'b1;
    drive(idle);
    #3;
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset mask", pending_mask, 32'h0);
    chk("reset inflight", 32'(inflight_cnt), 32'h0);
    chk("reset err", 32'(underflow_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mask", i), pending_mask, vecs[i].mask);
      chk($sformatf("v%0d inflight", i), 32'(inflight_cnt), 32'(vecs[i].infl));
      chk($sformatf("v%0d err", i), 32'(underflow_err), 32'(vecs[i].err));
    end

    // Mid-cycle reset with cnt[5]=2 and a stalled r5 reader
    @(negedge clk);
    drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'd0, 0));
    #1;
    chk("pre-reset stall", 32'(stall), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset stall", 32'(stall), 32'h0);
    chk("midreset mask", pending_mask, 32'h0);
    chk("midreset inflight", 32'(inflight_cnt), 32'h0);
    chk("midreset err", 32'(underflow_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    #1;
    chk("postreset stall", 32'(stall), 32'h0);

    // A stale WB to r5 after reset now counts as underflow
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 32'h0, 4'd0, 0));
    @(posedge clk);
    #1;
    chk("stale wb err", 32'(underflow_err), 32'h1);
    chk("stale wb inflight", 32'(inflight_cnt), 32'h0);
    chk("stale wb mask", pending_mask, 32'h0);
    @(negedge clk);
    drive(idle);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
